// File: rtl/inst_cache_fifo_pkg.sv
// Shared constants, address helpers and FSM encoding for the 2-way instruction cache.
// Line geometry is derived from the index/offset widths so the helpers stay consistent.
package inst_cache_fifo_pkg;

  localparam logic RST_ENABLE  = 1'b1;
  localparam logic RST_DISABLE = 1'b0;

  localparam int ADDR_WIDTH     = 32;
  localparam int DATA_WIDTH     = 32;
  localparam int INDEX_WIDTH    = 6;
  localparam int OFFSET_WIDTH   = 6;
  localparam int WAYS           = 2;
  localparam int WORD_SEL_WIDTH = OFFSET_WIDTH - 2;
  localparam int WORDS_PER_LINE = 1 << WORD_SEL_WIDTH;
  localparam int NUM_SETS       = 1 << INDEX_WIDTH;
  localparam int TAG_WIDTH      = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;

  typedef logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0] line_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOOKUP  = 3'd1,
    ST_MISS_AR = 3'd2,
    ST_MISS_R  = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

  // Addresses are carried without the two always-zero byte bits.
  function automatic logic [TAG_WIDTH-1:0] addr_tag(input logic [ADDR_WIDTH-1:2] a);
    return a[ADDR_WIDTH-1:INDEX_WIDTH+OFFSET_WIDTH];
  endfunction

  function automatic logic [INDEX_WIDTH-1:0] addr_index(input logic [ADDR_WIDTH-1:2] a);
    return a[INDEX_WIDTH+OFFSET_WIDTH-1:OFFSET_WIDTH];
  endfunction

  function automatic logic [WORD_SEL_WIDTH-1:0] addr_word(input logic [ADDR_WIDTH-1:2] a);
    return a[OFFSET_WIDTH-1:2];
  endfunction

endpackage

// File: rtl/inst_cache_fifo_if.sv
// CPU fetch channel plus memory refill channel of the instruction cache.
// Handshake: m_ar* transfers on the edge where m_arvalid && m_arready; a data beat transfers where m_rvalid && m_rready; s_rvalid is a one-cycle pulse with no back-pressure.
interface inst_cache_fifo_if;
  import inst_cache_fifo_pkg::*;

  logic                  cache_ena;
  logic                  flush;
  logic [ADDR_WIDTH-1:0] s_araddr;
  logic                  s_arvalid;
  logic [DATA_WIDTH-1:0] s_rdata;
  logic                  s_rvalid;
  logic [ADDR_WIDTH-1:0] m_araddr;
  logic                  m_arvalid;
  logic                  m_arready;
  logic [DATA_WIDTH-1:0] m_rdata;
  logic                  m_rvalid;
  logic                  m_rlast;
  logic                  m_rready;

  // Cache side.
  modport slave (
    input  cache_ena, flush, s_araddr, s_arvalid,
    output s_rdata, s_rvalid,
    output m_araddr, m_arvalid, m_rready,
    input  m_arready, m_rdata, m_rvalid, m_rlast
  );

  // CPU and memory side.
  modport master (
    output cache_ena, flush, s_araddr, s_arvalid,
    input  s_rdata, s_rvalid,
    input  m_araddr, m_arvalid, m_rready,
    output m_arready, m_rdata, m_rvalid, m_rlast
  );

endinterface

// File: rtl/inst_cache_fifo_way.sv
// One way of the cache: per-set valid bit (reset), tag and full line (not reset).
// Reads are combinational; a whole line is installed in a single write.
module icache_way_array
  import inst_cache_fifo_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [INDEX_WIDTH-1:0]    rd_index,
  input  logic [WORD_SEL_WIDTH-1:0] rd_word,
  output logic                      rd_valid,
  output logic [TAG_WIDTH-1:0]      rd_tag,
  output logic [DATA_WIDTH-1:0]     rd_data,
  input  logic                      wr_en,
  input  logic [INDEX_WIDTH-1:0]    wr_index,
  input  logic [TAG_WIDTH-1:0]      wr_tag,
  input  line_t                     wr_line
);

  logic [NUM_SETS-1:0]  valid_q;
  logic [TAG_WIDTH-1:0] tag_q [NUM_SETS];
  line_t                data_q [NUM_SETS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_line;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index][rd_word];

endmodule

// File: rtl/inst_cache_fifo.sv
// 2-way set-associative read-only instruction cache with per-set FIFO replacement.
// Hits answer in the cycle after the request; misses refill a whole line by burst first.
module inst_cache_fifo
  import inst_cache_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  inst_cache_fifo_if.slave  bus,
  output state_t            dbg_state
);

  state_t                    state_q, state_d;
  logic [ADDR_WIDTH-1:2]     addr_q;
  logic                      ena_q;
  logic                      cancel_q;
  logic [WORD_SEL_WIDTH-1:0] beat_cnt_q;
  line_t                     line_buf_q;
  logic [NUM_SETS-1:0]       fifo_ptr_q;

  logic [TAG_WIDTH-1:0]      req_tag;
  logic [INDEX_WIDTH-1:0]    req_index;
  logic [WORD_SEL_WIDTH-1:0] req_word;
  logic                      victim;
  logic                      install;
  logic                      accept;
  logic                      hit;
  logic [DATA_WIDTH-1:0]     hit_data;

  logic [WAYS-1:0]           way_valid;
  logic [WAYS-1:0]           way_hit;
  logic [WAYS-1:0]           way_wr_en;
  logic [TAG_WIDTH-1:0]      way_tag  [WAYS];
  logic [DATA_WIDTH-1:0]     way_data [WAYS];

  // Byte-lane bits of a word-aligned fetch carry no information.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.s_araddr[1:0];

  assign req_tag   = addr_tag(addr_q);
  assign req_index = addr_index(addr_q);
  assign req_word  = addr_word(addr_q);
  assign victim    = fifo_ptr_q[req_index];
  assign install   = (state_q == ST_RESP) && ena_q;
  assign accept    = (state_q == ST_IDLE) && bus.s_arvalid && !bus.flush;
  assign dbg_state = state_q;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    icache_way_array u_way (
      .clk      (clk),
      .rst      (rst),
      .rd_index (req_index),
      .rd_word  (req_word),
      .rd_valid (way_valid[g]),
      .rd_tag   (way_tag[g]),
      .rd_data  (way_data[g]),
      .wr_en    (way_wr_en[g]),
      .wr_index (req_index),
      .wr_tag   (req_tag),
      .wr_line  (line_buf_q)
    );
    assign way_hit[g]   = way_valid[g] && (way_tag[g] == req_tag);
    assign way_wr_en[g] = install && (int'(victim) == g);
  end

  assign hit = |way_hit;

  always_comb begin
    hit_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_hit[w]) hit_data = way_data[w];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) state_q <= ST_IDLE;
    else                   state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (accept) state_d = ST_LOOKUP;
      ST_LOOKUP: begin
        if (bus.flush)         state_d = ST_IDLE;
        else if (hit && ena_q) state_d = ST_IDLE;
        else                   state_d = ST_MISS_AR;
      end
      ST_MISS_AR: if (bus.m_arready) state_d = ST_MISS_R;
      ST_MISS_R:  if (bus.m_rvalid && bus.m_rlast) state_d = ST_RESP;
      ST_RESP:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    bus.s_rvalid  = 1'b0;
    bus.s_rdata   = '0;
    bus.m_arvalid = 1'b0;
    bus.m_araddr  = '0;
    bus.m_rready  = 1'b0;
    unique case (state_q)
      ST_LOOKUP: begin
        bus.s_rvalid = hit && ena_q && !bus.flush;
        if (bus.s_rvalid) bus.s_rdata = hit_data;
      end
      ST_MISS_AR: begin
        bus.m_arvalid = 1'b1;
        bus.m_araddr  = {addr_q[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
      end
      ST_MISS_R: bus.m_rready = 1'b1;
      ST_RESP: begin
        bus.s_rvalid = !cancel_q && !bus.flush;
        if (bus.s_rvalid) bus.s_rdata = line_buf_q[req_word];
      end
      default: ;
    endcase
  end

  // Request context, refill bookkeeping and replacement pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      addr_q     <= '0;
      ena_q      <= 1'b0;
      cancel_q   <= 1'b0;
      beat_cnt_q <= '0;
      fifo_ptr_q <= '0;
    end else begin
      if (accept) begin
        addr_q     <= bus.s_araddr[ADDR_WIDTH-1:2];
        ena_q      <= bus.cache_ena;
        cancel_q   <= 1'b0;
        beat_cnt_q <= '0;
      end
      // A flush during refill still lets the line land; only the reply is dropped.
      if (bus.flush && (state_q == ST_MISS_AR || state_q == ST_MISS_R)) begin
        cancel_q <= 1'b1;
      end
      if (state_q == ST_MISS_R && bus.m_rvalid) begin
        beat_cnt_q <= beat_cnt_q + 1'b1;
      end
      if (install) begin
        fifo_ptr_q[req_index] <= ~victim;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_MISS_R && bus.m_rvalid) begin
      line_buf_q[beat_cnt_q] <= bus.m_rdata;
    end
  end

endmodule

// File: tb/tb_inst_cache_fifo.sv
// Directed bench for inst_cache_fifo: a burst memory model returns data equal to the byte address of each word.
module tb_inst_cache_fifo;
  import inst_cache_fifo_pkg::*;

  logic   clk;
  logic   rst;
  state_t dbg_state;
  int     total_cnt;
  int     pass_cnt;
  int     ar_cnt;
  int     rv_cnt;
  logic [31:0] last_araddr;

  inst_cache_fifo_if bus ();

  inst_cache_fifo dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and reset.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: one burst of 16 beats per address, with a gap before beat 5
  // and an extra m_arready wait on every second request.
  initial begin
    logic [31:0] base;
    bus.m_arready = 1'b0;
    bus.m_rvalid  = 1'b0;
    bus.m_rlast   = 1'b0;
    bus.m_rdata   = '0;
    forever begin
      @(negedge clk);
      if (bus.m_arvalid === 1'b1) begin
        base        = bus.m_araddr;
        last_araddr = base;
        ar_cnt++;
        if (ar_cnt % 2 == 0) @(negedge clk);
        bus.m_arready = 1'b1;
        @(negedge clk);
        bus.m_arready = 1'b0;
        for (int b = 0; b < 16; b++) begin
          if (b == 5) begin
            bus.m_rvalid = 1'b0;
            @(negedge clk);
          end
          bus.m_rvalid = 1'b1;
          bus.m_rdata  = base + 32'(4 * b);
          bus.m_rlast  = (b == 15);
          @(negedge clk);
        end
        bus.m_rvalid = 1'b0;
        bus.m_rlast  = 1'b0;
      end
    end
  end

  // Response monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.s_rvalid === 1'b1) rv_cnt++;
    end
  end

  // Driver: issues one request and waits for the reply; lat counts cycles after the request edge.
  task automatic fetch(input logic [31:0] addr, input logic ena,
                       output logic [31:0] data, output int lat);
    @(negedge clk);
    bus.s_araddr  = addr;
    bus.s_arvalid = 1'b1;
    bus.cache_ena = ena;
    @(negedge clk);
    bus.s_arvalid = 1'b0;
    lat = 1;
    while (bus.s_rvalid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    data = bus.s_rdata;
    if (bus.s_rvalid !== 1'b1) begin
      total_cnt++;
      $display("FAIL fetch_timeout addr=%h: no s_rvalid, required within 100 cycles", addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++; if (bus.s_rvalid !== 1'b0) $display("FAIL reset_s_rvalid got=%b exp=0", bus.s_rvalid); else pass_cnt++;
    total_cnt++; if (bus.s_rdata !== 32'h0) $display("FAIL reset_s_rdata got=%h exp=0", bus.s_rdata); else pass_cnt++;
    total_cnt++; if (bus.m_arvalid !== 1'b0) $display("FAIL reset_m_arvalid got=%b exp=0", bus.m_arvalid); else pass_cnt++;
    total_cnt++; if (bus.m_araddr !== 32'h0) $display("FAIL reset_m_araddr got=%h exp=0", bus.m_araddr); else pass_cnt++;
    total_cnt++; if (bus.m_rready !== 1'b0) $display("FAIL reset_m_rready got=%b exp=0", bus.m_rready); else pass_cnt++;
    total_cnt++; if (dbg_state !== ST_IDLE) $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cold_miss_and_hit();
    logic [31:0] d;
    int lat, ar0;
    last_araddr = 32'hFFFF_FFFF;
    fetch(32'h04, 1'b1, d, lat);
    total_cnt++; if (last_araddr !== 32'h0) $display("FAIL cold_araddr got=%h exp=00000000", last_araddr); else pass_cnt++;
    total_cnt++; if (d !== 32'h04) $display("FAIL cold_data got=%h exp=00000004", d); else pass_cnt++;
    total_cnt++; if (lat <= 1) $display("FAIL cold_latency got=%0d exp>1", lat); else pass_cnt++;
    ar0 = ar_cnt;
    fetch(32'h08, 1'b1, d, lat);
    total_cnt++; if (d !== 32'h08) $display("FAIL hit_data got=%h exp=00000008", d); else pass_cnt++;
    total_cnt++; if (lat !== 1) $display("FAIL hit_latency got=%0d exp=1", lat); else pass_cnt++;
    total_cnt++; if (ar_cnt !== ar0) $display("FAIL hit_no_refill got=%0d exp=%0d", ar_cnt, ar0); else pass_cnt++;
  endtask

  task automatic test_second_line();
    logic [31:0] d;
    int lat;
    last_araddr = 32'hFFFF_FFFF;
    fetch(32'h4C, 1'b1, d, lat);
    total_cnt++; if (last_araddr !== 32'h40) $display("FAIL miss4c_araddr got=%h exp=00000040", last_araddr); else pass_cnt++;
    total_cnt++; if (d !== 32'h4C) $display("FAIL miss4c_data got=%h exp=0000004c", d); else pass_cnt++;
    fetch(32'h44, 1'b1, d, lat);
    total_cnt++; if (lat !== 1) $display("FAIL hit44_latency got=%0d exp=1", lat); else pass_cnt++;
    total_cnt++; if (d !== 32'h44) $display("FAIL hit44_data got=%h exp=00000044", d); else pass_cnt++;
    last_araddr = 32'hFFFF_FFFF;
    fetch(32'h80, 1'b1, d, lat);
    total_cnt++; if (last_araddr !== 32'h80) $display("FAIL miss80_araddr got=%h exp=00000080", last_araddr); else pass_cnt++;
    total_cnt++; if (d !== 32'h80) $display("FAIL miss80_data got=%h exp=00000080", d); else pass_cnt++;
  endtask

  // Set 0 already holds line 0x0000 in way 0; 0x1000 fills way 1, 0x2000 evicts way 0.
  task automatic test_fifo_eviction();
    logic [31:0] d;
    int lat, ar0;
    ar0 = ar_cnt;
    fetch(32'h1000, 1'b1, d, lat);
    fetch(32'h2000, 1'b1, d, lat);
    total_cnt++; if (ar_cnt !== ar0 + 2) $display("FAIL evict_fill_refills got=%0d exp=%0d", ar_cnt - ar0, 2); else pass_cnt++;
    total_cnt++; if (d !== 32'h2000) $display("FAIL evict_2000_data got=%h exp=00002000", d); else pass_cnt++;
    fetch(32'h1004, 1'b1, d, lat);
    total_cnt++; if (lat !== 1) $display("FAIL evict_1000_still_hits lat got=%0d exp=1", lat); else pass_cnt++;
    total_cnt++; if (d !== 32'h1004) $display("FAIL evict_1000_data got=%h exp=00001004", d); else pass_cnt++;
    ar0 = ar_cnt;
    last_araddr = 32'hFFFF_FFFF;
    fetch(32'h0, 1'b1, d, lat);
    total_cnt++; if (ar_cnt !== ar0 + 1) $display("FAIL evict_0000_misses refills got=%0d exp=1", ar_cnt - ar0); else pass_cnt++;
    total_cnt++; if (last_araddr !== 32'h0) $display("FAIL evict_0000_araddr got=%h exp=00000000", last_araddr); else pass_cnt++;
  endtask

  task automatic test_flush_idle();
    logic [31:0] d;
    int lat, ar0, rv0;
    ar0 = ar_cnt;
    rv0 = rv_cnt;
    @(negedge clk);
    bus.s_araddr  = 32'hFFFF_FFFF;
    bus.s_arvalid = 1'b1;
    bus.flush     = 1'b1;
    @(negedge clk);
    bus.s_arvalid = 1'b0;
    bus.flush     = 1'b0;
    repeat (10) @(negedge clk);
    total_cnt++; if (rv_cnt !== rv0) $display("FAIL flush_idle_rvalid got=%0d exp=%0d", rv_cnt, rv0); else pass_cnt++;
    total_cnt++; if (ar_cnt !== ar0) $display("FAIL flush_idle_arvalid got=%0d exp=%0d", ar_cnt, ar0); else pass_cnt++;
    fetch(32'h14, 1'b1, d, lat);
    total_cnt++; if (d !== 32'h14) $display("FAIL flush_next_data got=%h exp=00000014", d); else pass_cnt++;
  endtask

  task automatic test_flush_lookup();
    int ar0, rv0;
    ar0 = ar_cnt;
    rv0 = rv_cnt;
    @(negedge clk);
    bus.s_araddr  = 32'h180;
    bus.s_arvalid = 1'b1;
    bus.cache_ena = 1'b1;
    @(negedge clk);
    bus.s_arvalid = 1'b0;
    bus.flush     = 1'b1;
    @(negedge clk);
    bus.flush     = 1'b0;
    repeat (30) @(negedge clk);
    total_cnt++; if (rv_cnt !== rv0) $display("FAIL flush_lookup_rvalid got=%0d exp=%0d", rv_cnt, rv0); else pass_cnt++;
    total_cnt++; if (ar_cnt !== ar0) $display("FAIL flush_lookup_refill got=%0d exp=%0d", ar_cnt, ar0); else pass_cnt++;
  endtask

  task automatic test_flush_miss();
    logic [31:0] d;
    int lat, ar0, rv0;
    ar0 = ar_cnt;
    rv0 = rv_cnt;
    @(negedge clk);
    bus.s_araddr  = 32'h100;
    bus.s_arvalid = 1'b1;
    bus.cache_ena = 1'b1;
    @(negedge clk);
    bus.s_arvalid = 1'b0;
    repeat (8) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    repeat (40) @(negedge clk);
    total_cnt++; if (rv_cnt !== rv0) $display("FAIL flush_miss_rvalid got=%0d exp=%0d", rv_cnt, rv0); else pass_cnt++;
    total_cnt++; if (ar_cnt !== ar0 + 1) $display("FAIL flush_miss_refill got=%0d exp=1", ar_cnt - ar0); else pass_cnt++;
    fetch(32'h104, 1'b1, d, lat);
    total_cnt++; if (lat !== 1) $display("FAIL flush_miss_installed lat got=%0d exp=1", lat); else pass_cnt++;
    total_cnt++; if (d !== 32'h104) $display("FAIL flush_miss_data got=%h exp=00000104", d); else pass_cnt++;
  endtask

  task automatic test_cache_disable();
    logic [31:0] d;
    int lat, ar0;
    for (int i = 0; i < 2; i++) begin
      ar0 = ar_cnt;
      fetch(32'h04, 1'b0, d, lat);
      total_cnt++; if (d !== 32'h04) $display("FAIL nocache_data[%0d] got=%h exp=00000004", i, d); else pass_cnt++;
      total_cnt++; if (ar_cnt !== ar0 + 1) $display("FAIL nocache_refill[%0d] got=%0d exp=1", i, ar_cnt - ar0); else pass_cnt++;
    end
    fetch(32'h204, 1'b0, d, lat);
    ar0 = ar_cnt;
    fetch(32'h204, 1'b1, d, lat);
    total_cnt++; if (ar_cnt !== ar0 + 1) $display("FAIL nocache_no_alloc refills got=%0d exp=1", ar_cnt - ar0); else pass_cnt++;
    total_cnt++; if (d !== 32'h204) $display("FAIL nocache_alloc_data got=%h exp=00000204", d); else pass_cnt++;
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] d;
    int lat, ar0, rv0;
    @(negedge clk);
    bus.s_araddr  = 32'h300;
    bus.s_arvalid = 1'b1;
    bus.cache_ena = 1'b1;
    @(negedge clk);
    bus.s_arvalid = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total_cnt++; if (dbg_state !== ST_IDLE) $display("FAIL midreset_state got=%0d exp=%0d", dbg_state, ST_IDLE); else pass_cnt++;
    total_cnt++; if (bus.m_rready !== 1'b0) $display("FAIL midreset_m_rready got=%b exp=0", bus.m_rready); else pass_cnt++;
    rst = 1'b0;
    rv0 = rv_cnt;
    repeat (25) @(negedge clk);
    total_cnt++; if (rv_cnt !== rv0) $display("FAIL midreset_stray_rvalid got=%0d exp=%0d", rv_cnt, rv0); else pass_cnt++;
    ar0 = ar_cnt;
    fetch(32'h08, 1'b1, d, lat);
    total_cnt++; if (ar_cnt !== ar0 + 1) $display("FAIL midreset_invalidated refills got=%0d exp=1", ar_cnt - ar0); else pass_cnt++;
    total_cnt++; if (d !== 32'h08) $display("FAIL midreset_data got=%h exp=00000008", d); else pass_cnt++;
  endtask

  initial begin
    total_cnt     = 0;
    pass_cnt      = 0;
    ar_cnt        = 0;
    rv_cnt        = 0;
    last_araddr   = 32'hFFFF_FFFF;
    bus.cache_ena = 1'b1;
    bus.flush     = 1'b0;
    bus.s_araddr  = '0;
    bus.s_arvalid = 1'b0;
    test_reset();
    test_cold_miss_and_hit();
    test_second_line();
    test_fifo_eviction();
    test_flush_idle();
    test_flush_lookup();
    test_flush_miss();
    test_cache_disable();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
